// File: rtl/lms_plant_src.sv
// Stimulus source for LMS system identification. Emits a sample strobe, a noise or external
// reference sample, and that sample filtered through a programmable FIR plant using one serial MAC.
module lms_plant_src #(
  parameter int          TAPS = 16,
  parameter int          DIV  = 32,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic                      ext_sel,
  input  logic signed [15:0]        ext_din,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [15:0]        coef_data,
  output logic                      busy,
  output logic                      en,
  output logic signed [15:0]        din,
  output logic signed [15:0]        desired,
  output logic [15:0]               sample_cnt
);

  localparam int AW  = $clog2(TAPS);
  localparam int ACW = 32 + AW;
  localparam int CW  = $clog2(DIV);
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic signed [ACW-1:0] MAXV = ACW'(32767);
  localparam logic signed [ACW-1:0] MINV = ACW'(-32768);

  if (DIV < TAPS + 3) begin : g_div_check
    $error("lms_plant_src: DIV must be >= TAPS+3");
  end

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic signed [15:0]     x_q [TAPS];
  logic signed [15:0]     x_d [TAPS];
  logic signed [15:0]     h_q [TAPS];
  logic signed [15:0]     h_d [TAPS];
  logic signed [15:0]     pend_q, pend_d;
  logic [AW-1:0]          idx_q, idx_d;
  logic signed [ACW-1:0]  acc_q, acc_d;
  logic signed [15:0]     din_q, din_d;
  logic signed [15:0]     desired_q, desired_d;
  logic                   en_q, en_d;
  logic                   busy_q, busy_d;
  logic [15:0]            cnt_q, cnt_d;

  logic                   tick;
  logic [15:0]            lfsr_next;
  logic signed [15:0]     sample;
  logic signed [31:0]     prod;
  logic signed [ACW-1:0]  shifted;

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    x_d       = x_q;
    h_d       = h_q;
    pend_d    = pend_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    din_d     = din_q;
    desired_d = desired_q;
    en_d      = 1'b0;
    busy_d    = busy_q;
    cnt_d     = cnt_q;

    tick      = run && (count_q == '0);
    count_d   = !run ? '0 : (count_q == CW'(DIV - 1)) ? '0 : count_q + CW'(1);
    lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    sample    = ext_sel ? ext_din : $signed(lfsr_next);
    prod      = 32'(x_q[idx_q]) * 32'(h_q[idx_q]);
    shifted   = acc_q >>> 15;

    // Coefficients may only change between MAC sequences so a sample never sees a mixed plant.
    if (coef_we && !busy_q && !tick) h_d[coef_addr] = coef_data;

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          if (!ext_sel) lfsr_d = lfsr_next;
          x_d[0] = sample;
          for (int k = 1; k < TAPS; k++) x_d[k] = x_q[k-1];
          pend_d  = sample;
          acc_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + ACW'(prod);
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(TAPS - 1)) state_d = S_OUT;
      end
      S_OUT: begin
        if (shifted > MAXV)      desired_d = 16'sh7FFF;
        else if (shifted < MINV) desired_d = 16'sh8000;
        else                     desired_d = shifted[15:0];
        din_d   = pend_q;
        en_d    = 1'b1;
        cnt_d   = cnt_q + 16'd1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      lfsr_q    <= SEED_EFF;
      for (int k = 0; k < TAPS; k++) begin
        x_q[k] <= '0;
        h_q[k] <= '0;
      end
      pend_q    <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      din_q     <= '0;
      desired_q <= '0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      lfsr_q    <= lfsr_d;
      x_q       <= x_d;
      h_q       <= h_d;
      pend_q    <= pend_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      din_q     <= din_d;
      desired_q <= desired_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
    end
  end

  assign busy       = busy_q;
  assign en         = en_q;
  assign din        = din_q;
  assign desired    = desired_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_lms_plant_src.sv
// Bench for lms_plant_src: a sample-level plant model predicts every en pulse and its
// din/desired/sample_cnt; directed sequences add literal expectations on top.
module tb_lms_plant_src;

  localparam int TAPS = 16;
  localparam int DIV  = 32;
  localparam int AW   = $clog2(TAPS);

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          run = 1'b0;
  logic          ext_sel = 1'b0;
  logic [15:0]   ext_din = '0;
  logic          coef_we = 1'b0;
  logic [AW-1:0] coef_addr = '0;
  logic [15:0]   coef_data = '0;
  logic          busy, en;
  logic [15:0]   din, desired, sample_cnt;

  lms_plant_src #(.TAPS(TAPS), .DIV(DIV), .SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .run(run), .ext_sel(ext_sel), .ext_din(ext_din),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .busy(busy), .en(en), .din(din), .desired(desired), .sample_cnt(sample_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at cycle", name, got, exp);
  endtask

  function automatic logic [15:0] sat16(input longint v);
    longint s;
    s = v >>> 15;
    if (s > 32767)       return 16'h7FFF;
    else if (s < -32768) return 16'h8000;
    else                 return 16'(s);
  endfunction

  // Sample-level model: one entry per tick, {due_cycle, din, desired}.
  logic [63:0] exp_q[$];
  int          cyc = 0;
  int          m_phase, m_busy_left, m_cnt;
  logic [15:0] m_lfsr, m_din, m_des;
  int          m_x [TAPS];
  int          m_h [TAPS];

  always @(posedge clk) begin
    logic        busy_now, tk;
    logic [15:0] s;
    longint      acc;
    if (rst) begin
      exp_q.delete();
      m_phase = 0; m_busy_left = 0; m_cnt = 0;
      m_lfsr = 16'hACE1; m_din = '0; m_des = '0;
      for (int k = 0; k < TAPS; k++) begin m_x[k] = 0; m_h[k] = 0; end
    end else begin
      busy_now = (m_busy_left > 0);
      if (m_busy_left > 0) m_busy_left--;
      tk = run && (m_phase == 0);
      if (coef_we && !busy_now && !tk) m_h[coef_addr] = int'($signed(coef_data));
      if (tk) begin
        if (!ext_sel)
          m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        s = ext_sel ? ext_din : m_lfsr;
        for (int k = TAPS - 1; k > 0; k--) m_x[k] = m_x[k-1];
        m_x[0] = int'($signed(s));
        acc = 0;
        for (int k = 0; k < TAPS; k++) acc += longint'(m_x[k]) * longint'(m_h[k]);
        exp_q.push_back({32'(cyc + TAPS + 2), s, sat16(acc)});
        m_busy_left = TAPS + 1;
      end
      m_phase = run ? (m_phase + 1) % DIV : 0;
    end
    cyc++;
  end

  // Compare every cycle outside reset.
  always @(negedge clk) begin
    logic        exp_en;
    logic [63:0] e;
    if (!rst) begin
      exp_en = (exp_q.size() > 0) && (exp_q[0][63:32] == 32'(cyc));
      if (exp_en) begin
        e = exp_q.pop_front();
        m_din = e[31:16];
        m_des = e[15:0];
        m_cnt++;
      end
      check("en", 32'(en), 32'(exp_en));
      check("busy", 32'(busy), 32'(m_busy_left > 0));
      check("din", 32'(din), 32'(m_din));
      check("desired", 32'(desired), 32'(m_des));
      check("sample_cnt", 32'(sample_cnt), 32'(16'(m_cnt)));
    end
  end

  // driver tasks
  task automatic wait_en(input string tag);
    for (int k = 0; k < 4 * DIV; k++) begin
      @(negedge clk);
      if (en === 1'b1) break;
    end
    check(tag, 32'(en), 32'd1);
  endtask

  task automatic write_coef(input int addr, input logic [15:0] data);
    coef_we = 1'b1; coef_addr = AW'(addr); coef_data = data;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_en"}, 32'(en), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_din"}, 32'(din), 32'd0);
    check({tag, "_desired"}, 32'(desired), 32'd0);
    check({tag, "_cnt"}, 32'(sample_cnt), 32'd0);
  endtask

  task automatic reset_dut(input string tag);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_zero_outputs(tag);
    run = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic sat_case(input logic [15:0] x, input logic [15:0] h,
                          input logic [15:0] e1, input logic [15:0] e2);
    reset_dut("rst_sat");
    ext_sel = 1'b1; ext_din = x;
    for (int k = 0; k < TAPS; k++) write_coef(k, h);
    run = 1'b1;
    wait_en("en_sat1");
    check("sat_first", 32'(desired), 32'(e1));
    wait_en("en_sat2");
    check("sat_second", 32'(desired), 32'(e2));
    run = 1'b0;
  endtask

  initial begin
    int c0, en_seen;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;

    // h[0] = 0.5, LFSR source: latency, literal values, sample spacing
    write_coef(0, 16'h4000);
    run = 1'b1;
    c0 = cyc;
    wait_en("en_first");
    check("latency", 32'(cyc - c0), 32'(TAPS + 2));
    check("first_din", 32'(din), 32'h59C3);
    check("first_desired", 32'(desired), 32'h2CE1);
    check("first_cnt", 32'(sample_cnt), 32'd1);
    c0 = cyc;
    wait_en("en_second");
    check("period", 32'(cyc - c0), 32'(DIV));

    // dropped writes: during MAC, then coincident with the tick
    repeat (DIV - TAPS - 2 + 3) @(negedge clk);
    write_coef(0, 16'h0000);
    wait_en("en_busy_wr");
    check("busy_wr_dropped", 32'(desired != 16'h0000), 32'd1);
    repeat (DIV - TAPS - 2) @(negedge clk);
    write_coef(0, 16'h0000);
    wait_en("en_tick_wr");
    check("tick_wr_dropped", 32'(desired != 16'h0000), 32'd1);
    write_coef(0, 16'h0000);
    wait_en("en_idle_wr");
    check("idle_wr_applied", 32'(desired), 32'd0);

    // run dropped 3 cycles after a tick
    reset_dut("rst_rundrop");
    run = 1'b1;
    repeat (3) @(negedge clk);
    run = 1'b0;
    wait_en("en_after_drop");
    en_seen = 0;
    repeat (3 * DIV) begin
      @(negedge clk);
      if (en) en_seen++;
    end
    check("no_ticks_idle", 32'(en_seen), 32'd0);
    run = 1'b1;
    c0 = cyc;
    wait_en("en_rerun");
    check("rerun_latency", 32'(cyc - c0), 32'(TAPS + 2));

    // reset in the middle of a MAC sequence
    run = 1'b0;
    reset_dut("rst_pre_mac");
    write_coef(1, 16'h2000);
    run = 1'b1;
    repeat (5) @(negedge clk);
    check("busy_mid_mac", 32'(busy), 32'd1);
    reset_dut("rst_mid_mac");
    run = 1'b1;
    wait_en("en_after_rst");
    check("restart_din", 32'(din), 32'h59C3);
    check("restart_desired", 32'(desired), 32'd0);
    run = 1'b0;

    // single-tap plant at delay 3
    reset_dut("rst_h3");
    write_coef(3, 16'h7FFF);
    run = 1'b1;
    for (int i = 0; i < 200; i++) begin
      wait_en("en_h3");
      if (i == 0) check("h3_din0", 32'(din), 32'h59C3);
      if (i < 3) check("h3_zero", 32'(desired), 32'd0);
      if (i == 3) check("h3_delayed", 32'(desired), 32'h59C2);
    end
    run = 1'b0;

    // output saturation
    sat_case(16'h7FFF, 16'h7FFF, 16'h7FFE, 16'h7FFF);
    sat_case(16'h8000, 16'h7FFF, 16'h8001, 16'h8000);
    sat_case(16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF);

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lms_plant_src.md
Name: lms_plant_src

Overview:
- Stimulus/plant source that drives the input side of the LMS adaptive filter.
- Produces the sample strobe `en`, the reference input `din` (16-bit LFSR noise or an external sample) and `desired`.
- `desired` is `din` passed through a programmable fixed FIR "unknown plant", computed serially on one MAC.
- Used for system-identification runs: the adaptive filter consumes `en`/`din`/`desired` and should converge to the plant coefficients.

Parameters:
- TAPS, 16: plant FIR length; power of two, 2..64.
- DIV, 32: clocks per sample period; must be >= TAPS+3 (checked at elaboration).
- SEED, 16'hACE1: LFSR reset value; a value of 0 is replaced by 16'h0001.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  enable sample generation.
- ext_sel  in  1  1 = sample source is ext_din; 0 = LFSR.
- ext_din  in  16  external signed sample, captured at the sample tick.
- coef_we  in  1  plant coefficient write strobe.
- coef_addr  in  log2(TAPS)  coefficient index.
- coef_data  in  16  signed Q1.15 coefficient.
- busy  out  1  MAC sequence in progress.
- en  out  1  one-cycle strobe: din/desired are valid and new.
- din  out  16  signed sample delivered to the adaptive filter.
- desired  out  16  signed plant output, Q1.15, saturated.
- sample_cnt  out  16  count of en pulses, wraps 16'hFFFF -> 0.

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values:
  - lfsr = SEED; plant delay line all 0; coefficients all 0.
  - Divider count = 0; state = IDLE.
  - en = 0, busy = 0, din = 0, desired = 0, sample_cnt = 0.
- Reset mid-MAC: abort immediately, no en pulse.
- Divider:
  - While run = 1, the count runs 0..DIV-1 and wraps.
  - Sample tick = (run && count == 0).
  - run = 0: count is held at 0, so the first tick occurs on the first cycle run is seen high.
- At tick, in one cycle:
  - LFSR advances one step: Fibonacci x^16+x^14+x^13+x^11+1, new = l[15]^l[13]^l[12]^l[10], l <= {l[14:0], new}.
  - LFSR advances only when ext_sel = 0; it is frozen when ext_sel = 1.
  - The sample s (the new LFSR value, or ext_din) is shifted into delay line x[0]; x[k] <= x[k-1].
  - s is latched as pending din; state IDLE -> MAC.
- State MAC, TAPS cycles:
  - Cycle i adds x[i]*h[i] (signed 16x16 -> 32) into a 32+log2(TAPS)-bit accumulator.
  - The accumulator is cleared at MAC entry.
  - busy = 1 throughout MAC and OUT.
- State OUT, 1 cycle:
  - desired <= sat16(acc >>> 15): arithmetic shift, truncation toward -inf, clamp to [16'h8000, 16'h7FFF].
  - din <= pending sample; en <= 1 on the following cycle for exactly one clock.
  - sample_cnt increments with en; state -> IDLE.
- Latency: en is asserted TAPS+2 clocks after the tick cycle. din and desired hold until the next en.
- Coefficient writes:
  - Writes h[coef_addr] <= coef_data only when busy = 0 and no tick occurs in the same cycle.
  - Otherwise the write is ignored (silently dropped).
- run deasserted mid-sequence: the current MAC/OUT completes and en fires. Then the count is held at 0.
- Tick while busy: cannot occur given DIV >= TAPS+3.
- Saturation applies only at the output; the accumulator never overflows, because guard bits cover TAPS * 2^30.

Test Plan:
- Reset, run = 1, ext_sel = 0, h[0] = 16'h4000, others 0 -> first en at tick+TAPS+2; din = 16'h59C3, desired = 16'h2CE1, sample_cnt = 1; next en exactly DIV clocks later.
- h[3] = 16'h7FFF only, LFSR source -> desired[k] = floor(din[k-3]*32767/32768); desired = 0 for the first 3 samples; checked against a reference model for 200 samples.
- ext_sel = 1, ext_din = 16'h7FFF, all h = 16'h7FFF -> desired rises, then clamps at 16'h7FFF from the 2nd sample on. ext_din = 16'h8000, all h = 16'h7FFF -> clamps at 16'h8000. ext_din = 16'h8000, all h = 16'h8000 -> 16'h7FFF.
- coef_we pulsed during busy, and coincident with a tick -> coefficient unchanged on readback via output; the same write while idle takes effect at the next sample.
- run dropped 3 cycles after a tick -> that en still fires; no further ticks; count = 0. Re-assert run -> tick on the first cycle.
- rst asserted mid-MAC -> all outputs 0 asynchronously; no en; after release, the LFSR restarts from SEED (first din = 16'h59C3 again).
